// File: rtl/whack_judge.sv
// whack_judge: player-side judge for the whack-a-mole game.
// Debounces five hole buttons and judges each press as a hit or a miss
// against the generator's moles word. It issues one-cycle kill pulses and
// keeps the score, the miss count and the game timer.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      level; starts a game from IDLE or restarts it from OVER
//   btn[4:0]   raw asynchronous buttons, bit i = hole i, active high
//   moles[19:0] generator status, nibble i nonzero = mole in hole i
//   kill_list  registered one-cycle kill pulse per hole
//   score      saturating score (clamped to SCORE_MAX)
//   miss_cnt   presses on empty holes, saturating at 255
//   playing    high in PLAY
//   game_over  high in OVER
//   time_left  remaining PLAY cycles
//
// State table:
//   IDLE | after reset; waits for start, presses discarded
//   PLAY | game running; time_left counts down, presses judged
//   OVER | time expired; score/miss frozen, start begins a new game
module whack_judge #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAME_CYCLES     = 1000,
  parameter int SCORE_MAX       = 9999,
  parameter int HIT_POINTS      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  btn,
  input  logic [19:0] moles,
  output logic [4:0]  kill_list,
  output logic [15:0] score,
  output logic [7:0]  miss_cnt,
  output logic        playing,
  output logic        game_over,
  output logic [31:0] time_left
);

  localparam int              CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   DB_TC     = CW'(DEBOUNCE_CYCLES);
  localparam logic [18:0]     SCORE_CAP = 19'(SCORE_MAX);
  localparam logic [18:0]     POINTS    = 19'(HIT_POINTS);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t        state;
  logic [4:0]    sync1, sync2;
  logic [4:0]    deb, deb_d;
  logic [CW-1:0] cnt [5];
  logic [4:0]    lock;

  logic [4:0]    press;
  logic [4:0]    field_nz;
  logic [4:0]    hit, miss;
  logic [2:0]    hit_n, miss_n;
  logic [18:0]   score_sum;
  logic [15:0]   score_next;
  logic [8:0]    miss_sum;
  logic [7:0]    miss_next;

  // Synchronizer and debouncer run in every state so the debounced level
  // always tracks the pads; only the judging is gated by PLAY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_TC) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press    = deb & ~deb_d;
    field_nz = '0;
    for (int i = 0; i < 5; i++) field_nz[i] = |moles[4*i +: 4];
    // A locked hole with a mole still present is neither hit nor miss.
    hit      = press & field_nz & ~lock & {5{state == PLAY}};
    miss     = press & ~field_nz & {5{state == PLAY}};
    hit_n    = '0;
    miss_n   = '0;
    for (int i = 0; i < 5; i++) begin
      hit_n  = hit_n + {2'b00, hit[i]};
      miss_n = miss_n + {2'b00, miss[i]};
    end
    score_sum  = {3'b000, score} + POINTS * {16'h0000, hit_n};
    score_next = (score_sum > SCORE_CAP) ? SCORE_CAP[15:0] : score_sum[15:0];
    miss_sum   = {1'b0, miss_cnt} + {6'b000000, miss_n};
    miss_next  = miss_sum[8] ? 8'hFF : miss_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      kill_list <= '0;
      score     <= '0;
      miss_cnt  <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      time_left <= '0;
      lock      <= '0;
    end else begin
      kill_list <= hit;
      // Lock is held until the generator clears the mole.
      lock      <= (lock | hit) & field_nz;
      unique case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= PLAY;
            playing   <= 1'b1;
            game_over <= 1'b0;
            score     <= '0;
            miss_cnt  <= '0;
            time_left <= 32'(GAME_CYCLES);
            lock      <= '0;
          end
        end
        PLAY: begin
          score    <= score_next;
          miss_cnt <= miss_next;
          if (time_left == 32'd1) begin
            state     <= OVER;
            playing   <= 1'b0;
            game_over <= 1'b1;
            time_left <= '0;
          end else begin
            time_left <= time_left - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_whack_judge.sv
// Testbench for whack_judge: table-driven judging vectors, hand-written
// sequences for timer, latency, lockout, saturation and reset, and a
// randomized run checked every cycle against a behavioural model.
module tb_whack_judge;

  localparam int DB   = 4;
  localparam int GAME = 1000;
  localparam int SMAX = 9999;
  localparam int SSAT = 2;
  localparam int HP   = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  btn;
  logic [19:0] moles;

  logic [4:0]  kill_list, kill_sat;
  logic [15:0] score, score_sat;
  logic [7:0]  miss_cnt, miss_sat;
  logic        playing, playing_sat;
  logic        game_over, game_over_sat;
  logic [31:0] time_left, time_left_sat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  whack_judge #(.DEBOUNCE_CYCLES(DB), .GAME_CYCLES(GAME), .SCORE_MAX(SMAX), .HIT_POINTS(HP)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .moles(moles),
    .kill_list(kill_list), .score(score), .miss_cnt(miss_cnt),
    .playing(playing), .game_over(game_over), .time_left(time_left));

  whack_judge #(.DEBOUNCE_CYCLES(DB), .GAME_CYCLES(GAME), .SCORE_MAX(SSAT), .HIT_POINTS(HP)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .moles(moles),
    .kill_list(kill_sat), .score(score_sat), .miss_cnt(miss_sat),
    .playing(playing_sat), .game_over(game_over_sat), .time_left(time_left_sat));

  // ---------------- behavioural model ----------------
  // hist holds the raw button samples of the last DB+3 edges, oldest first.
  // The synchronized value seen at edge n is the raw sample of edge n-2, and
  // the debounced level flips once DB+1 consecutive synchronized samples
  // disagree with it.
  logic [4:0] hist[$];
  logic [4:0] m_lvl, m_press, m_lock, m_kill;
  int m_phase;   // 0 idle, 1 play, 2 over
  int m_rem, m_score, m_score_sat, m_miss;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < DB + 3; k++) hist.push_back(5'b00000);
    m_lvl = '0; m_press = '0; m_lock = '0; m_kill = '0;
    m_phase = 0; m_rem = 0; m_score = 0; m_score_sat = 0; m_miss = 0;
  endtask

  task automatic model_step();
    logic [4:0] nz, hits, new_lvl;
    int nh, nm;
    bit all_diff;
    for (int i = 0; i < 5; i++) nz[i] = (moles[4*i +: 4] != 4'h0);
    hits = '0; nh = 0; nm = 0;
    if (m_phase == 1) begin
      for (int i = 0; i < 5; i++) begin
        if (m_press[i]) begin
          if (nz[i] && !m_lock[i]) begin hits[i] = 1'b1; nh++; end
          else if (!nz[i]) nm++;
        end
      end
    end
    m_kill = hits;
    m_lock = (m_lock | hits) & nz;
    if (m_phase == 1) begin
      m_score     = (m_score + nh * HP > SMAX) ? SMAX : m_score + nh * HP;
      m_score_sat = (m_score_sat + nh * HP > SSAT) ? SSAT : m_score_sat + nh * HP;
      m_miss      = (m_miss + nm > 255) ? 255 : m_miss + nm;
      if (m_rem == 1) begin m_phase = 2; m_rem = 0; end
      else m_rem = m_rem - 1;
    end else if (start) begin
      m_phase = 1; m_rem = GAME; m_score = 0; m_score_sat = 0; m_miss = 0; m_lock = '0;
    end
    hist.push_back(btn);
    void'(hist.pop_front());
    new_lvl = m_lvl;
    for (int i = 0; i < 5; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k <= DB; k++) if (hist[k][i] == m_lvl[i]) all_diff = 1'b0;
      if (all_diff) new_lvl[i] = ~m_lvl[i];
    end
    m_press = new_lvl & ~m_lvl;
    m_lvl   = new_lvl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("kill_list", 32'(kill_list), 32'(m_kill));
    chk("score", 32'(score), 32'(m_score));
    chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    chk("playing", 32'(playing), 32'(m_phase == 1));
    chk("game_over", 32'(game_over), 32'(m_phase == 2));
    chk("time_left", time_left, 32'(m_rem));
    chk("sat_kill", 32'(kill_sat), 32'(m_kill));
    chk("sat_score", 32'(score_sat), 32'(m_score_sat));
    chk("sat_miss", 32'(miss_sat), 32'(m_miss));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  // ---------------- judging vectors ----------------
  typedef struct {
    logic [19:0] moles;
    logic [4:0]  btn;
    int          width;
    logic [4:0]  exp_kill;
    int          exp_ds;
    int          exp_dm;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, m0, kill_cyc, sat_hits, guard;
    logic [4:0] kill_or;

    vecs[0] = '{20'h00050, 5'b00010, 10, 5'b00010, 1, 0};  // hit hole 1
    vecs[1] = '{20'h00050, 5'b00010, 10, 5'b00000, 0, 0};  // lockout
    vecs[2] = '{20'h00000, 5'b00010, 10, 5'b00000, 0, 1};  // miss
    vecs[3] = '{20'h00050, 5'b00010,  2, 5'b00000, 0, 0};  // glitch
    vecs[4] = '{20'h10101, 5'b11111, 10, 5'b10101, 3, 2};  // simultaneous
    vecs[5] = '{20'h10101, 5'b00100, 10, 5'b00000, 0, 0};  // still locked
    vecs[6] = '{20'h01000, 5'b01000, 10, 5'b01000, 1, 0};  // hole 3 hit

    rst_n = 1'b0; start = 1'b0; btn = '0; moles = '0;
    model_reset();
    repeat (3) tick();
    chk("reset_playing", 32'(playing), 32'd0);
    chk("reset_time_left", time_left, 32'd0);
    rst_n = 1'b1;
    tick();

    // game timer
    start = 1'b1; tick(); start = 1'b0;
    chk("start_playing", 32'(playing), 32'd1);
    chk("start_time_left", time_left, 32'd1000);
    repeat (GAME - 1) tick();
    chk("last_cycle_time_left", time_left, 32'd1);
    tick();
    chk("end_game_over", 32'(game_over), 32'd1);
    chk("end_playing", 32'(playing), 32'd0);
    chk("end_time_left", time_left, 32'd0);

    // restart from OVER, then kill latency on hole 3
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_time_left", time_left, 32'd1000);
    moles = 20'h01000; tick();
    btn = 5'b01000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("latency_k%0d", k), 32'(kill_list), (k == 8) ? 32'h8 : 32'h0);
    end
    btn = '0; moles = '0;
    repeat (8) tick();
    chk("latency_score", 32'(score), 32'd1);

    // table-driven judging
    sat_hits = 0;
    for (int v = 0; v < 7; v++) begin
      s0 = int'(score); m0 = int'(miss_cnt);
      kill_or = '0; kill_cyc = 0;
      moles = vecs[v].moles; tick();
      btn = vecs[v].btn;
      for (int c = 0; c < vecs[v].width; c++) begin
        tick();
        kill_or |= kill_list; kill_cyc += (kill_list != 0);
        sat_hits += $countones(kill_sat);
      end
      btn = '0;
      for (int c = 0; c < 12; c++) begin
        tick();
        kill_or |= kill_list; kill_cyc += (kill_list != 0);
        sat_hits += $countones(kill_sat);
      end
      chk($sformatf("vec%0d_kill", v), 32'(kill_or), 32'(vecs[v].exp_kill));
      chk($sformatf("vec%0d_kill_cycles", v), 32'(kill_cyc), (vecs[v].exp_kill != 0) ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_dscore", v), 32'(int'(score) - s0), 32'(vecs[v].exp_ds));
      chk($sformatf("vec%0d_dmiss", v), 32'(int'(miss_cnt) - m0), 32'(vecs[v].exp_dm));
    end
    chk("sat_score_capped", 32'(score_sat), 32'd2);
    chk("sat_kill_pulses", 32'(sat_hits), 32'd5);

    // run out the game, then presses in OVER are discarded
    guard = 0;
    while (!game_over && guard < 1200) begin tick(); guard++; end
    chk("reach_over", 32'(game_over), 32'd1);
    s0 = int'(score); m0 = int'(miss_cnt); kill_or = '0;
    moles = 20'h00001; btn = 5'b00001;
    repeat (10) begin tick(); kill_or |= kill_list; end
    btn = 5'b00010;
    repeat (10) begin tick(); kill_or |= kill_list; end
    btn = '0;
    repeat (8) begin tick(); kill_or |= kill_list; end
    chk("over_kill", 32'(kill_or), 32'd0);
    chk("over_score", 32'(score), 32'(s0));
    chk("over_miss", 32'(miss_cnt), 32'(m0));

    // reset mid-game while a debounce is in progress
    start = 1'b1; tick(); start = 1'b0;
    moles = 20'h00100; tick();
    btn = 5'b00100; repeat (10) tick();
    btn = '0; repeat (8) tick();
    chk("pre_reset_score", 32'(score), 32'd1);
    moles = 20'h00050; btn = 5'b00010;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_kill", 32'(kill_list), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_time_left", time_left, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    kill_or = '0;
    repeat (12) begin tick(); kill_or |= kill_list; end
    chk("idle_kill", 32'(kill_or), 32'd0);
    chk("idle_playing", 32'(playing), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("fresh_score", 32'(score), 32'd0);
    chk("fresh_time_left", time_left, 32'd1000);
    kill_or = '0;
    repeat (10) begin tick(); kill_or |= kill_list; end
    chk("held_no_event", 32'(kill_or), 32'd0);
    btn = '0;

    // randomized run against the model
    for (int it = 0; it < 2500; it++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 5; i++)
          moles[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      start = ($urandom_range(0, 199) == 0);
      tick();
    end
    start = 1'b0; btn = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/whack_judge.md
Name: whack_judge

Overview:
- Player-side counterpart of the mole generator: it produces the `kill_list` that the generator consumes and watches the generator's `moles` status word.
- Debounces five hole buttons, judges each press as a hit or a miss against the current `moles` field, and issues one-cycle kill pulses.
- Keeps score, miss count and the game timer (IDLE/PLAY/OVER).
- Sits between the button pads and MOLE; feeds the score and timer to the display logic.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles needed to accept a button level change (>=1).
- GAME_CYCLES, 1000, length of a game in clk cycles (>=1).
- SCORE_MAX, 9999, saturation value of score.
- HIT_POINTS, 1, score added per hit.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; starts or restarts a game.
- btn  in  5  raw asynchronous buttons, bit i = hole i, active high.
- moles  in  20  generator status; field i = moles[4i+3:4i]; nonzero = mole present in hole i.
- kill_list  out  5  registered one-cycle pulse per hole to the generator.
- score  out  16  current score, saturating.
- miss_cnt  out  8  presses on empty holes, saturating at 255.
- playing  out  1  high in PLAY.
- game_over  out  1  high in OVER.
- time_left  out  32  remaining PLAY cycles.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - kill_list, score, miss_cnt, playing, game_over, time_left = 0.
  - Synchronizers, debounced levels, debounce counters and lockouts cleared.
  - Reset mid-game aborts immediately; no kill pulse is emitted.
- Input path, per button:
  - 2-flop synchronizer.
  - Debounce counter: resets whenever the synchronized level equals the debounced level, otherwise increments.
  - The debounced level flips when the counter reaches DEBOUNCE_CYCLES.
  - A press event is a debounced 0->1 transition, one cycle wide. Releases generate no event.
  - Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no event.
- Latency: btn held high before clk edge t gives kill_list high during cycle t+DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES + 1 output register). It stays high for exactly 1 cycle.
- FSM:
  - IDLE: start=1 -> PLAY. On entry: score=0, miss_cnt=0, time_left=GAME_CYCLES, lockouts cleared.
  - PLAY:
    - time_left decrements by 1 each cycle.
    - Cycle in which time_left==1 -> OVER next cycle, with time_left=0.
    - start is ignored.
  - OVER: game_over=1; score and miss_cnt frozen; start=1 -> PLAY with the same entry actions as from IDLE.
  - Press events outside PLAY are discarded: no kill, no score, no miss. The debouncer still tracks the buttons.
- Judging (PLAY only), per hole i, evaluated independently in the same cycle:
  - Event with field i != 0 and lock[i]=0 -> hit:
    - kill_list[i]=1 next cycle.
    - lock[i] set.
    - Counts toward the score increment.
  - Event with field i == 0 -> miss: miss_cnt+1, saturating.
  - Event with lock[i]=1 and field i != 0 -> ignored. This prevents double-kill while the generator has not yet cleared the mole.
  - lock[i] clears on any cycle in which field i == 0.
- Simultaneous events:
  - score += HIT_POINTS × (number of hits this cycle), computed at 19 bits and clamped to SCORE_MAX.
  - miss_cnt += number of misses this cycle, clamped to 255.
  - Hits and misses in the same cycle are both applied.
- A hit in the last PLAY cycle (time_left==1) still emits its kill pulse and is scored.
- Score at SCORE_MAX stays at SCORE_MAX; kill pulses are still issued.
- moles is assumed synchronous to clk (same-clock generator); it is sampled directly with no synchronizer.

Test Plan:
1. Reset then start=1 for 1 cycle -> playing=1, time_left=1000, decrementing by 1 per cycle. After 1000 cycles: game_over=1, playing=0, time_left=0.
2. moles=20'h00050 (hole 1 present); btn=5'b00010 held for 10 cycles -> kill_list=5'b00010 for exactly 1 cycle, 7 cycles after the first high sample; score=1. Keep moles unchanged and press again -> no kill, score stays 1 (lockout). Clear moles, press again -> miss_cnt=1.
3. btn pulse 2 cycles wide (< DEBOUNCE_CYCLES) with mole present -> no kill_list, score and miss unchanged.
4. moles=20'h10101 (holes 0, 2, 4 present); btn=5'b11111 -> kill_list=5'b10101 in a single cycle; score+=3; miss_cnt+=2.
5. SCORE_MAX=2, three separate hits -> score stays at 2, and all three kill pulses are emitted. Press while in IDLE or OVER -> no pulse, counters unchanged.
6. rst_n deasserted low for 3 cycles mid-PLAY while a debounce is in progress -> all outputs 0 immediately and state IDLE. After reset, a held button produces no event in IDLE; start=1 then gives a fresh game with score=0.
